regfile_wb_arbiter: RTL and testbench

Write-back arbiter and buffer that sits between the CPU's two result producers (ALU and load/store unit) and the single write port of the 32 x 64 integer register bank. It accepts results over valid/ready handshakes, arbitrates round-robin, and queues them in a small FIFO. It drains one entry per cycle into the register bank's write port. It also exports a pending-write bitmap and a youngest-match forwarding port so issue logic can detect and bypass in-flight write-backs.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: round-robin accept of ALU/LSU results into a small FIFO
// that drains one entry per cycle into the register bank write port.
module regfile_wb_arbiter #(
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [$clog2(REG_NUM)-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [$clog2(REG_NUM)-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       wb_hold,
  output logic                       write_en,
  output logic [$clog2(REG_NUM)-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]      wb_data,
  output logic [REG_NUM-1:0]         pending,
  input  logic [$clog2(REG_NUM)-1:0] fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_WIDTH-1:0]      fwd_data
);
  localparam int unsigned AW = $clog2(REG_NUM);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  last_grant_q, last_grant_d;
  logic [AW-1:0]         addr_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         addr_mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];

  logic                  pop_c, space_ok_c;
  logic                  alu_gnt_c, lsu_gnt_c;
  logic                  alu_hs_c, lsu_hs_c, push_c;
  logic [AW-1:0]         in_addr_c;
  logic [DATA_WIDTH-1:0] in_data_c;

  // Arbitration, handshakes and FIFO next state
  always_comb begin
    pop_c        = !reset && (count_q != '0) && !wb_hold;
    space_ok_c   = (count_q < CW'(FIFO_DEPTH)) || pop_c;
    alu_gnt_c    = alu_valid && (!lsu_valid || last_grant_q);
    lsu_gnt_c    = lsu_valid && (!alu_valid || !last_grant_q);
    // x0 results are accepted even when full since they never occupy a slot
    alu_ready    = !reset && alu_gnt_c && (space_ok_c || (alu_addr == '0));
    lsu_ready    = !reset && lsu_gnt_c && (space_ok_c || (lsu_addr == '0));
    alu_hs_c     = alu_valid && alu_ready;
    lsu_hs_c     = lsu_valid && lsu_ready;
    in_addr_c    = lsu_hs_c ? lsu_addr : alu_addr;
    in_data_c    = lsu_hs_c ? lsu_data : alu_data;
    push_c       = (alu_hs_c || lsu_hs_c) && (in_addr_c != '0);

    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    last_grant_d = last_grant_q;
    addr_mem_d   = addr_mem_q;
    data_mem_d   = data_mem_q;
    if (push_c) begin
      addr_mem_d[wr_ptr_q] = in_addr_c;
      data_mem_d[wr_ptr_q] = in_data_c;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (alu_hs_c || lsu_hs_c) begin
      last_grant_d = lsu_hs_c;
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  // Write port driven straight from the FIFO head
  always_comb begin
    write_en   = pop_c;
    write_addr = '0;
    wb_data    = '0;
    if (pop_c) begin
      write_addr = addr_mem_q[rd_ptr_q];
      wb_data    = data_mem_q[rd_ptr_q];
    end
  end

  // Pending bitmap and forwarding; scanning oldest to youngest lets the last match win
  always_comb begin
    pending  = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      if (!reset && (CW'(k) < count_q)) begin
        pending[addr_mem_q[rd_ptr_q + PW'(k)]] = 1'b1;
        if ((fwd_addr != '0) && (addr_mem_q[rd_ptr_q + PW'(k)] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem_q[rd_ptr_q + PW'(k)];
        end
      end
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Payload storage needs no reset; count alone decides which entries are valid
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned DW      = 64;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned AW      = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] alu_addr, lsu_addr, write_addr, fwd_addr;
  logic [DW-1:0] alu_data, lsu_data, wb_data, fwd_data;
  logic          wb_hold, write_en, fwd_hit;
  logic [REG_NUM-1:0] pending;

  regfile_wb_arbiter #(.REG_NUM(REG_NUM), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .wb_hold(wb_hold), .write_en(write_en), .write_addr(write_addr), .wb_data(wb_data),
    .pending(pending), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;
  int zero_wr  = 0;

  // model state
  ent_t q[$];
  logic lg = 1'b1;
  logic model_on = 1'b0;
  logic s_reset = 1'b1, s_pop, s_alu_hs, s_lsu_hs;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // One compare pass per cycle against the queue model
  task automatic model_cycle();
    logic e_pop, space, ga, gl, e_ar, e_lr, e_hit;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd, e_fd;
    logic [REG_NUM-1:0] e_pend;
    e_pop = 0; ga = 0; gl = 0; e_ar = 0; e_lr = 0; e_hit = 0;
    e_wa = '0; e_wd = '0; e_fd = '0; e_pend = '0;
    if (!reset) begin
      e_pop = (q.size() > 0) && !wb_hold;
      space = (q.size() < DEPTH) || e_pop;
      if (alu_valid && lsu_valid) begin
        ga = lg;
        gl = !lg;
      end else begin
        ga = alu_valid;
        gl = lsu_valid;
      end
      e_ar = ga && (space || alu_addr == 0);
      e_lr = gl && (space || lsu_addr == 0);
      if (e_pop) begin
        e_wa = q[0].a;
        e_wd = q[0].d;
      end
      foreach (q[i]) begin
        e_pend[q[i].a] = 1'b1;
        if (fwd_addr != 0 && q[i].a == fwd_addr) begin
          e_hit = 1'b1;
          e_fd  = q[i].d;
        end
      end
    end
    chk("m_alu_ready", 64'(alu_ready), 64'(e_ar));
    chk("m_lsu_ready", 64'(lsu_ready), 64'(e_lr));
    chk("m_write_en", 64'(write_en), 64'(e_pop));
    chk("m_write_addr", 64'(write_addr), 64'(e_wa));
    chk("m_wb_data", wb_data, e_wd);
    chk("m_pending", 64'(pending), 64'(e_pend));
    chk("m_fwd_hit", 64'(fwd_hit), 64'(e_hit));
    chk("m_fwd_data", fwd_data, e_fd);
    if (write_en && write_addr == 0) zero_wr++;
    s_pop    = e_pop;
    s_alu_hs = alu_valid && e_ar;
    s_lsu_hs = lsu_valid && e_lr;
    s_addr   = s_lsu_hs ? lsu_addr : alu_addr;
    s_data   = s_lsu_hs ? lsu_data : alu_data;
  endtask

  task automatic do_reset();
    reset = 1'b1; alu_valid = 0; lsu_valid = 0; wb_hold = 0;
    at_neg();
    chk("rst_write_en", 64'(write_en), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; alu_valid = 0; lsu_valid = 0; wb_hold = 0; fwd_addr = 0;
    alu_addr = 0; lsu_addr = 0; alu_data = 0; lsu_data = 0;

    fork
      forever begin
        @(negedge clk);
        if (model_on) model_cycle();
        s_reset = reset;
        @(posedge clk);
        if (s_reset) begin
          q.delete();
          lg = 1'b1;
          model_on = 1'b1;
        end else if (model_on) begin
          if (s_pop) void'(q.pop_front());
          if ((s_alu_hs || s_lsu_hs) && s_addr != 0) q.push_back('{a: s_addr, d: s_data});
          if (s_alu_hs || s_lsu_hs) lg = s_lsu_hs;
        end
      end
    join_none

    // single push
    do_reset();
    alu_valid = 1; alu_addr = 5; alu_data = 64'hDEAD;
    at_neg(); chk("t1_alu_ready", 64'(alu_ready), 64'd1);
    step(); alu_valid = 0;
    at_neg();
    chk("t1_write_en", 64'(write_en), 64'd1);
    chk("t1_write_addr", 64'(write_addr), 64'd5);
    chk("t1_wb_data", wb_data, 64'hDEAD);
    chk("t1_pending", 64'(pending), 64'h20);
    step();
    at_neg();
    chk("t1_write_en_off", 64'(write_en), 64'd0);
    chk("t1_pending_off", 64'(pending), 64'd0);
    step();

    // round-robin on ties: ALU, LSU, ALU, LSU
    do_reset();
    alu_valid = 1; lsu_valid = 1; alu_addr = 1; lsu_addr = 2;
    alu_data = 64'hA1; lsu_data = 64'hB2;
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) begin alu_valid = 0; lsu_valid = 0; end
      at_neg();
      if (i < 4) begin
        chk("t2_alu_ready", 64'(alu_ready), 64'(i % 2 == 0));
        chk("t2_lsu_ready", 64'(lsu_ready), 64'(i % 2 == 1));
      end
      if (i >= 1 && i <= 4) begin
        chk("t2_write_addr", 64'(write_addr), ((i - 1) % 2 == 0) ? 64'd1 : 64'd2);
        chk("t2_wb_data", wb_data, ((i - 1) % 2 == 0) ? 64'hA1 : 64'hB2);
      end else begin
        chk("t2_write_en", 64'(write_en), 64'd0);
      end
      step();
    end

    // fill under hold, then accept-while-draining
    do_reset();
    wb_hold = 1; alu_valid = 1;
    for (int i = 0; i < 5; i++) begin
      alu_addr = AW'(3 + i); alu_data = 64'(32'h100 + i);
      at_neg();
      chk("t3_fill_ready", 64'(alu_ready), 64'(i < 4));
      chk("t3_fill_wen", 64'(write_en), 64'd0);
      step();
    end
    at_neg();
    chk("t3_full_ready", 64'(alu_ready), 64'd0);
    chk("t3_full_pending", 64'(pending), 64'h78);
    step();
    wb_hold = 0;
    at_neg();
    chk("t3_swap_ready", 64'(alu_ready), 64'd1);
    chk("t3_swap_addr", 64'(write_addr), 64'd3);
    step();
    alu_valid = 0;
    for (int j = 0; j < 4; j++) begin
      at_neg();
      chk("t3_drain_addr", 64'(write_addr), 64'(4 + j));
      chk("t3_drain_data", wb_data, 64'(32'h101 + j));
      step();
    end
    at_neg();
    chk("t3_empty_wen", 64'(write_en), 64'd0);
    step();

    // x0 result discarded even with FIFO full
    do_reset();
    wb_hold = 1; alu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_addr = AW'(10 + i); alu_data = 64'(32'h200 + i);
      at_neg(); chk("t4_fill_ready", 64'(alu_ready), 64'd1);
      step();
    end
    alu_valid = 0; lsu_valid = 1; lsu_addr = 0; lsu_data = 64'hBAD;
    at_neg();
    chk("t4_x0_ready", 64'(lsu_ready), 64'd1);
    chk("t4_x0_pending", 64'(pending), 64'h3C00);
    step();
    lsu_valid = 0; alu_valid = 1; alu_addr = 14;
    at_neg(); chk("t4_still_full", 64'(alu_ready), 64'd0);
    step();
    alu_valid = 0; wb_hold = 0;
    for (int j = 0; j < 4; j++) begin
      at_neg(); chk("t4_drain_addr", 64'(write_addr), 64'(10 + j));
      step();
    end
    at_neg(); chk("t4_empty_wen", 64'(write_en), 64'd0);
    step();

    // forwarding returns the youngest match
    do_reset();
    wb_hold = 1; fwd_addr = 9; alu_valid = 1; alu_addr = 9; alu_data = 64'h11;
    at_neg();
    chk("t5_push_invisible", 64'(fwd_hit), 64'd0);
    step();
    alu_data = 64'h22;
    at_neg();
    chk("t5_first_hit", 64'(fwd_hit), 64'd1);
    chk("t5_first_data", fwd_data, 64'h11);
    step();
    alu_valid = 0;
    at_neg();
    chk("t5_young_hit", 64'(fwd_hit), 64'd1);
    chk("t5_young_data", fwd_data, 64'h22);
    chk("t5_pending", 64'(pending), 64'h200);
    step();
    fwd_addr = 0;
    at_neg();
    chk("t5_x0_hit", 64'(fwd_hit), 64'd0);
    chk("t5_x0_data", fwd_data, 64'd0);
    step();
    fwd_addr = 9; wb_hold = 0;
    at_neg();
    chk("t5_pop_wb", wb_data, 64'h11);
    chk("t5_pop_fwd", fwd_data, 64'h22);
    step();
    at_neg();
    chk("t5_last_hit", 64'(fwd_hit), 64'd1);
    chk("t5_last_fwd", fwd_data, 64'h22);
    step();
    at_neg();
    chk("t5_gone_hit", 64'(fwd_hit), 64'd0);
    step();

    // reset with entries queued
    do_reset();
    wb_hold = 1; alu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_addr = AW'(20 + i); alu_data = 64'(32'h300 + i);
      step();
    end
    reset = 1; alu_valid = 1; lsu_valid = 1; alu_addr = 1; lsu_addr = 2;
    alu_data = 64'h501; lsu_data = 64'h502;
    at_neg();
    chk("t6_rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("t6_rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("t6_rst_wen", 64'(write_en), 64'd0);
    chk("t6_rst_pending", 64'(pending), 64'd0);
    step();
    reset = 0; wb_hold = 0;
    at_neg();
    chk("t6_tie_alu", 64'(alu_ready), 64'd1);
    chk("t6_tie_lsu", 64'(lsu_ready), 64'd0);
    chk("t6_empty_wen", 64'(write_en), 64'd0);
    chk("t6_empty_pending", 64'(pending), 64'd0);
    step();
    alu_valid = 0; lsu_valid = 0;
    at_neg();
    chk("t6_first_addr", 64'(write_addr), 64'd1);
    chk("t6_first_data", wb_data, 64'h501);
    step();
    at_neg();
    chk("t6_done_wen", 64'(write_en), 64'd0);
    step();

    chk("x0_never_written", 64'(zero_wr), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
